pcalc_rs: RTL and testbench

Reservation stage that feeds the point-calculation unit. It accepts hit records (rayID, triID, barycentric uv, t_int) from the intersection side and reads each ray's direction/origin vector from the ray-vector store. It pairs every record with its vector and presents complete `rs_to_pcalc_t` entries, in order, on a valid/stall interface to `pcalc_unit`. Internal buffering is credit-protected, so the stage never drops or overwrites an entry.

---
 rtl/pcalc_rs.sv | 163 ++++++++++++++++
 tb/tb_pcalc_rs.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcalc_rs.sv
// Reservation stage for the point-calculation unit: joins hit records with their
// ray vector from the ray-vector store and queues the pairs in a credit-protected FIFO.

package pcalc_pkg;

    typedef logic [7:0]  rayID_t;
    typedef logic [15:0] triID_t;
    typedef logic [31:0] float_t;

    typedef struct packed {
        float_t u;
        float_t v;
    } bari_uv_t;

    typedef struct packed {
        float_t x;
        float_t y;
        float_t z;
    } vec3_t;

    typedef struct packed {
        vec3_t origin;
        vec3_t dir;
    } ray_vec_t;

    typedef struct packed {
        rayID_t   rayID;
        bari_uv_t uv;
        float_t   t_int;
        triID_t   triID;
    } int_to_rs_t;

    typedef struct packed {
        rayID_t   rayID;
        bari_uv_t uv;
        float_t   t_int;
        triID_t   triID;
        ray_vec_t ray_vec;
    } rs_to_pcalc_t;

endpackage

module pcalc_rs
    import pcalc_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int DEPTH  = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                int_to_rs_valid,
    input  logic [$bits(int_to_rs_t)-1:0]       int_to_rs_data,
    output logic                                int_to_rs_stall,
    output logic                                raystore_re,
    output logic [$bits(rayID_t)-1:0]           raystore_raddr,
    input  logic [$bits(ray_vec_t)-1:0]         raystore_rdata,
    output logic                                rs_to_pcalc_valid,
    output logic [$bits(rs_to_pcalc_t)-1:0]     rs_to_pcalc_data,
    input  logic                                rs_to_pcalc_stall
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    int_to_rs_t      in_rec;
    logic            acc;
    logic            pop;
    logic            wr;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   fifo_cnt;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [RD_LAT-1:0] pipe_vld;
    int_to_rs_t      pipe_rec [RD_LAT];
    rs_to_pcalc_t    join_entry;
    rs_to_pcalc_t    fifo_mem [DEPTH];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign in_rec          = int_to_rs_data;
    assign int_to_rs_stall = rst | (cnt == FULL);
    assign acc             = int_to_rs_valid & ~int_to_rs_stall;
    assign raystore_re     = acc;
    assign raystore_raddr  = in_rec.rayID;

    // Credits cover records in the read pipe as well as in the FIFO, so a write can never find it full.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (acc && !pop) begin
            cnt <= cnt + 1'b1;
        end else if (pop && !acc) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= acc;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    // NOTE: payload registers and FIFO storage carry no reset; only the valids and pointers qualify them.
    always_ff @(posedge clk) begin
        pipe_rec[0] <= in_rec;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_rec[i] <= pipe_rec[i-1];
        end
    end

    assign wr = pipe_vld[RD_LAT-1];

    // NOTE: every field is assigned on every pass, so no latch can be inferred.
    always_comb begin
        join_entry.rayID   = pipe_rec[RD_LAT-1].rayID;
        join_entry.uv      = pipe_rec[RD_LAT-1].uv;
        join_entry.t_int   = pipe_rec[RD_LAT-1].t_int;
        join_entry.triID   = pipe_rec[RD_LAT-1].triID;
        join_entry.ray_vec = raystore_rdata;
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            fifo_mem[wr_ptr] <= join_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (wr && !pop) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (pop && !wr) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end
        end
    end

    // Head is forced to zero while empty so stale or uninitialised storage never leaks out.
    assign rs_to_pcalc_valid = (fifo_cnt != '0);
    assign pop               = rs_to_pcalc_valid & ~rs_to_pcalc_stall;
    assign rs_to_pcalc_data  = rs_to_pcalc_valid ? fifo_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_pcalc_rs.sv
// Directed bench for pcalc_rs: a ray-store model with exact read latency, an in-order
// scoreboard per instance, and cycle-accurate checks of stall, latency and ordering.

module tb_pcalc_rs;
    import pcalc_pkg::*;

    localparam int RD_LAT   = 2;
    localparam int DEPTH    = 4;
    localparam int S_RD_LAT = 1;
    localparam int S_DEPTH  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid;
    int_to_rs_t   in_rec;
    logic         in_stall;
    logic         rs_re;
    rayID_t       rs_raddr;
    ray_vec_t     rs_rdata = '0;
    logic         out_valid;
    rs_to_pcalc_t out_data;
    logic         out_stall;

    logic         s_valid;
    int_to_rs_t   s_rec;
    logic         s_stall;
    logic         s_re;
    rayID_t       s_raddr;
    ray_vec_t     s_rdata = '0;
    logic         s_out_valid;
    rs_to_pcalc_t s_out_data;
    logic         s_out_stall;

    pcalc_rs #(.RD_LAT(RD_LAT), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .int_to_rs_valid   (in_valid),
        .int_to_rs_data    (in_rec),
        .int_to_rs_stall   (in_stall),
        .raystore_re       (rs_re),
        .raystore_raddr    (rs_raddr),
        .raystore_rdata    (rs_rdata),
        .rs_to_pcalc_valid (out_valid),
        .rs_to_pcalc_data  (out_data),
        .rs_to_pcalc_stall (out_stall)
    );

    pcalc_rs #(.RD_LAT(S_RD_LAT), .DEPTH(S_DEPTH)) dut_small (
        .clk               (clk),
        .rst               (rst),
        .int_to_rs_valid   (s_valid),
        .int_to_rs_data    (s_rec),
        .int_to_rs_stall   (s_stall),
        .raystore_re       (s_re),
        .raystore_raddr    (s_raddr),
        .raystore_rdata    (s_rdata),
        .rs_to_pcalc_valid (s_out_valid),
        .rs_to_pcalc_data  (s_out_data),
        .rs_to_pcalc_stall (s_out_stall)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ray_vec_t rand_vec();
        ray_vec_t v;
        v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return v;
    endfunction

    function automatic int_to_rs_t mk_rec(input int id);
        int_to_rs_t r;
        r.rayID = rayID_t'(id);
        r.uv.u  = $urandom;
        r.uv.v  = $urandom;
        r.t_int = $urandom;
        r.triID = triID_t'(id + 256);
        return r;
    endfunction

    function automatic rs_to_pcalc_t mk_exp(input int_to_rs_t r, input ray_vec_t v);
        rs_to_pcalc_t e;
        e.rayID   = r.rayID;
        e.uv      = r.uv;
        e.t_int   = r.t_int;
        e.triID   = r.triID;
        e.ray_vec = v;
        return e;
    endfunction

    // Ray-vector store model: data is correct only in the due cycle, junk otherwise.
    ray_vec_t vec_mem [256];
    rayID_t   due_main  [int];
    rayID_t   due_small [int];
    int       cyc = 0;

    always @(negedge clk) begin
        if (rs_re) due_main[cyc + RD_LAT] = rs_raddr;
        if (s_re)  due_small[cyc + S_RD_LAT] = s_raddr;
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (due_main.exists(cyc)) begin
            rs_rdata = vec_mem[due_main[cyc]];
            due_main.delete(cyc);
        end else begin
            rs_rdata = rand_vec();
        end
        if (due_small.exists(cyc)) begin
            s_rdata = vec_mem[due_small[cyc]];
            due_small.delete(cyc);
        end else begin
            s_rdata = rand_vec();
        end
    end

    // In-order scoreboards, flushed by reset.
    rs_to_pcalc_t exp_q[$];
    rs_to_pcalc_t s_exp_q[$];

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            s_exp_q.delete();
        end else begin
            if (out_valid && !out_stall) begin
                check("main_pop_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("main_order", out_data, exp_q.pop_front());
            end
            if (in_valid && !in_stall) exp_q.push_back(mk_exp(in_rec, vec_mem[in_rec.rayID]));
            if (s_out_valid && !s_out_stall) begin
                check("small_pop_expected", s_exp_q.size() != 0, 1'b1);
                if (s_exp_q.size() != 0) check("small_order", s_out_data, s_exp_q.pop_front());
            end
            if (s_valid && !s_stall) s_exp_q.push_back(mk_exp(s_rec, vec_mem[s_rec.rayID]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        out_stall   = 1'b0;
        s_out_stall = 1'b0;
        while ((out_valid || exp_q.size() != 0 || s_out_valid || s_exp_q.size() != 0) && k < 60) begin
            tick();
            k++;
        end
        check("drain_done", k < 60, 1'b1);
    endtask

    task automatic offer_stalled(input int base, output int n_acc);
        int id;
        n_acc     = 0;
        id        = base;
        out_stall = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = (n_acc < 6);
            in_rec   = mk_rec(id);
            @(negedge clk);
            if (in_valid && !in_stall) begin
                n_acc++;
                id++;
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    ray_vec_t     v5;
    int_to_rs_t   rec5;
    rs_to_pcalc_t exp5;
    int           n_acc;
    int           n_bad;
    int           sid;
    int           s_total;
    bit           hist [30];

    initial begin
        for (int i = 0; i < 256; i++) vec_mem[i] = rand_vec();
        v5 = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 32'h66666666};
        vec_mem[5] = v5;

        rst         = 1'b1;
        in_valid    = 1'b1;
        in_rec      = mk_rec(0);
        out_stall   = 1'b0;
        s_valid     = 1'b0;
        s_rec       = '0;
        s_out_stall = 1'b0;

        // Reset held three cycles with a record offered.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_stall", in_stall, 1'b1);
            check("rst_re", rs_re, 1'b0);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_out_data", out_data, '0);
            tick();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("release_stall", in_stall, 1'b0);
        tick();

        // Single record, held through four stalled cycles.
        rec5       = mk_rec(5);
        rec5.triID = 16'h0012;
        rec5.t_int = 32'h3F800000;
        exp5       = mk_exp(rec5, v5);
        in_valid   = 1'b1;
        in_rec     = rec5;
        out_stall  = 1'b1;
        @(negedge clk);
        check("single_re", rs_re, 1'b1);
        check("single_raddr", rs_raddr, 8'd5);
        check("single_n_valid", out_valid, 1'b0);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            check("single_early_valid", out_valid, 1'b0);
            tick();
        end
        @(negedge clk);
        check("single_rayID", out_data.rayID, 8'd5);
        check("single_triID", out_data.triID, 16'h0012);
        check("single_t_int", out_data.t_int, 32'h3F800000);
        check("single_vec", out_data.ray_vec, v5);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check("single_hold_valid", out_valid, 1'b1);
            check("single_hold_data", out_data, exp5);
            tick();
        end
        out_stall = 1'b0;
        @(negedge clk);
        check("single_pop_valid", out_valid, 1'b1);
        tick();
        @(negedge clk);
        check("single_after_pop", out_valid, 1'b0);
        tick();

        // Streaming ten back-to-back records.
        for (int i = 0; i < 14; i++) begin
            in_valid = (i < 10);
            in_rec   = mk_rec(i);
            @(negedge clk);
            if (i < 10) check("stream_stall", in_stall, 1'b0);
            if (i >= 3 && i <= 12) begin
                check("stream_valid", out_valid, 1'b1);
                check("stream_rayID", out_data.rayID, rayID_t'(i - 3));
            end else begin
                check("stream_idle", out_valid, 1'b0);
            end
            tick();
        end
        in_valid = 1'b0;
        drain();

        // Back-pressure: only DEPTH credits.
        offer_stalled(30, n_acc);
        check("bp_accepts", n_acc, 4);
        out_stall = 1'b0;
        @(negedge clk);
        check("bp_full_stall", in_stall, 1'b1);
        check("bp_pop_valid", out_valid, 1'b1);
        tick();
        @(negedge clk);
        check("bp_stall_released", in_stall, 1'b0);
        tick();
        in_rec    = mk_rec(35);
        out_stall = 1'b1;
        @(negedge clk);
        check("bp_cnt_held", in_stall, 1'b0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_full_again", in_stall, 1'b1);
        tick();
        drain();

        // Reset with three records in flight.
        out_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_rec   = mk_rec(40 + i);
            @(negedge clk);
            check("mid_accept", in_stall, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_stall", in_stall, 1'b1);
        tick();
        rst   = 1'b0;
        n_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) n_bad++;
            tick();
        end
        check("mid_no_ghost", n_bad, 0);
        offer_stalled(50, n_acc);
        check("mid_credits", n_acc, 4);
        in_valid = 1'b0;
        drain();

        // RD_LAT=1, DEPTH=2: credit loop limits the accept rate.
        sid     = 100;
        s_total = 0;
        for (int i = 0; i < 30; i++) begin
            s_valid = 1'b1;
            s_rec   = mk_rec(sid);
            @(negedge clk);
            hist[i] = s_valid && !s_stall;
            if (hist[i]) begin
                sid++;
                s_total++;
            end
            tick();
        end
        s_valid = 1'b0;
        n_bad   = 0;
        for (int i = 2; i < 30; i++) begin
            if (int'(hist[i]) + int'(hist[i-1]) + int'(hist[i-2]) > 2) n_bad++;
        end
        check("sweep_window", n_bad, 0);
        check("sweep_total", s_total, 20);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
